// File: rtl/mc_control_unit_if.sv
// Bus between the multicycle control unit (master) and the datapath (slave):
// opcode / memory handshake in, datapath strobes, selects and status out.
interface mc_control_unit_if #(
  parameter int OPW    = 6,
  parameter int ALUOPW = 2
);
  logic [OPW-1:0]    opcode;
  logic              mem_ready;
  logic              pcwrite;
  logic              pcwritecond;
  logic              iord;
  logic              memread;
  logic              memwrite;
  logic              irwrite;
  logic              memtoreg;
  logic              regdst;
  logic              regwrite;
  logic              alusrca;
  logic [1:0]        alusrcb;
  logic [1:0]        pcsource;
  logic [ALUOPW-1:0] aluop;
  logic [3:0]        state;
  logic              done;
  logic              mem_timeout;
  logic              illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdst, regwrite, alusrca, alusrcb, pcsource, aluop, state, done,
           mem_timeout, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdst, regwrite, alusrca, alusrcb, pcsource, aluop, state, done,
           mem_timeout, illegal_op
  );
endinterface

// File: rtl/mc_control_unit.sv
// Moore-FSM control unit for the multicycle MIPS datapath with memory-stall watchdog.
// Optional trap on unknown opcodes: define MC_CTRL_TRAP_EN.
module mc_control_unit #(
  parameter int OPW         = 6,
  parameter int ALUOPW      = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  mc_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam int              CNTW    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MEM_TIMEOUT);

  // Zero-extending the code makes any set bit above [5:0] a non-match.
  function automatic logic op_is(input logic [OPW-1:0] op, input logic [5:0] code);
    return op == OPW'(code);
  endfunction

  state_t            state_reg, state_next;
  logic [CNTW-1:0]   wait_cnt_reg, wait_cnt_next;
  logic              timeout_reg;
  logic              in_wait;
  logic              wait_entry;

  logic              pcwrite_reg;
  logic              pcwritecond_reg;
  logic              iord_reg;
  logic              memread_reg;
  logic              memwrite_reg;
  logic              memtoreg_reg;
  logic              regdst_reg;
  logic              regwrite_reg;
  logic              alusrca_reg;
  logic [1:0]        alusrcb_reg;
  logic [1:0]        pcsource_reg;
  logic [ALUOPW-1:0] aluop_reg;
  logic              done_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        if (op_is(bus.opcode, OP_RTYPE))
          state_next = S_EXEC;
        else if (op_is(bus.opcode, OP_LW) || op_is(bus.opcode, OP_SW))
          state_next = S_MEMADR;
        else if (op_is(bus.opcode, OP_BEQ))
          state_next = S_BRANCH;
        else if (op_is(bus.opcode, OP_J))
          state_next = S_JUMP;
        else if (op_is(bus.opcode, OP_ADDI))
          state_next = S_ADDIEX;
        else
`ifdef MC_CTRL_TRAP_EN
          state_next = S_TRAP;
`else
          state_next = S_FETCH;
`endif
      end
      S_MEMADR: begin
        if (op_is(bus.opcode, OP_SW))
          state_next = S_MEMWR;
        else if (op_is(bus.opcode, OP_LW))
          state_next = S_MEMRD;
        else
          state_next = S_FETCH;
      end
      S_MEMRD:  if (bus.mem_ready) state_next = S_MEMWB;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  if (bus.mem_ready) state_next = S_FETCH;
      S_EXEC:   state_next = S_ALUWB;
      S_ALUWB:  state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_ADDIEX: state_next = S_ADDIWB;
      S_ADDIWB: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_IDLE;
    endcase
  end

  // Wait counter restarts whenever a memory-access state is freshly entered.
  assign in_wait    = (state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);
  assign wait_entry = ((state_next == S_FETCH) || (state_next == S_MEMRD) || (state_next == S_MEMWR))
                      && (state_next != state_reg);

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (wait_entry)
      wait_cnt_next = '0;
    else if (in_wait && !bus.mem_ready && (wait_cnt_reg != CNT_MAX))
      wait_cnt_next = wait_cnt_reg + 1'b1;
  end

  // Moore outputs are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      wait_cnt_reg    <= '0;
      timeout_reg     <= 1'b0;
      pcwrite_reg     <= 1'b0;
      pcwritecond_reg <= 1'b0;
      iord_reg        <= 1'b0;
      memread_reg     <= 1'b0;
      memwrite_reg    <= 1'b0;
      memtoreg_reg    <= 1'b0;
      regdst_reg      <= 1'b0;
      regwrite_reg    <= 1'b0;
      alusrca_reg     <= 1'b0;
      alusrcb_reg     <= 2'b00;
      pcsource_reg    <= 2'b00;
      aluop_reg       <= '0;
      done_reg        <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (wait_cnt_reg == CNT_MAX)
        timeout_reg <= 1'b1;

      pcwrite_reg     <= 1'b0;
      pcwritecond_reg <= 1'b0;
      iord_reg        <= 1'b0;
      memread_reg     <= 1'b0;
      memwrite_reg    <= 1'b0;
      memtoreg_reg    <= 1'b0;
      regdst_reg      <= 1'b0;
      regwrite_reg    <= 1'b0;
      alusrca_reg     <= 1'b0;
      alusrcb_reg     <= 2'b00;
      pcsource_reg    <= 2'b00;
      aluop_reg       <= '0;
      done_reg        <= 1'b0;

      case (state_next)
        S_FETCH: begin
          memread_reg <= 1'b1;
          alusrcb_reg <= 2'b01;
        end
        S_DECODE: alusrcb_reg <= 2'b11;
        S_MEMADR: begin
          alusrca_reg <= 1'b1;
          alusrcb_reg <= 2'b10;
        end
        S_MEMRD: begin
          memread_reg <= 1'b1;
          iord_reg    <= 1'b1;
        end
        S_MEMWB: begin
          regwrite_reg <= 1'b1;
          done_reg     <= 1'b1;
        end
        S_MEMWR: begin
          memwrite_reg <= 1'b1;
          iord_reg     <= 1'b1;
        end
        S_EXEC: begin
          alusrca_reg <= 1'b1;
          aluop_reg   <= ALUOPW'(2'b10);
        end
        S_ALUWB: begin
          regdst_reg   <= 1'b1;
          regwrite_reg <= 1'b1;
          memtoreg_reg <= 1'b1;
          done_reg     <= 1'b1;
        end
        S_BRANCH: begin
          alusrca_reg     <= 1'b1;
          aluop_reg       <= ALUOPW'(2'b01);
          pcwritecond_reg <= 1'b1;
          pcsource_reg    <= 2'b01;
          done_reg        <= 1'b1;
        end
        S_ADDIEX: begin
          alusrca_reg <= 1'b1;
          alusrcb_reg <= 2'b10;
        end
        S_ADDIWB: begin
          regwrite_reg <= 1'b1;
          memtoreg_reg <= 1'b1;
          done_reg     <= 1'b1;
        end
        S_JUMP: begin
          pcwrite_reg  <= 1'b1;
          pcsource_reg <= 2'b10;
          done_reg     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MC_CTRL_TRAP_EN
  logic illegal_reg;

  always_ff @(posedge clk) begin
    if (rst)
      illegal_reg <= 1'b0;
    else
      illegal_reg <= (state_next == S_TRAP);
  end

  assign bus.illegal_op = illegal_reg;
`else
  assign bus.illegal_op = 1'b0;
`endif

  // Only the handshake-completion strobes follow mem_ready within the cycle.
  assign bus.pcwrite     = pcwrite_reg | ((state_reg == S_FETCH) & bus.mem_ready);
  assign bus.irwrite     = (state_reg == S_FETCH) & bus.mem_ready;
  assign bus.done        = done_reg | ((state_reg == S_MEMWR) & bus.mem_ready);
  assign bus.pcwritecond = pcwritecond_reg;
  assign bus.iord        = iord_reg;
  assign bus.memread     = memread_reg;
  assign bus.memwrite    = memwrite_reg;
  assign bus.memtoreg    = memtoreg_reg;
  assign bus.regdst      = regdst_reg;
  assign bus.regwrite    = regwrite_reg;
  assign bus.alusrca     = alusrca_reg;
  assign bus.alusrcb     = alusrcb_reg;
  assign bus.pcsource    = pcsource_reg;
  assign bus.aluop       = aluop_reg;
  assign bus.state       = state_reg;
  assign bus.mem_timeout = timeout_reg;

endmodule
